control_unit_mc: RTL and testbench
==================================

Name: control_unit_mc

Overview:
- Parametrised multi-cycle successor to the processor control unit.
- Sequences instruction fetch, decode, execute, data/port memory access and writeback over Wishbone-style handshakes.
- Adds NUM_IRQ prioritised, maskable interrupt sources, a wait-for-interrupt state and a bus-timeout fault trap.
- Sits between the instruction/data buses and the datapath (ALU, register file, PC unit).

Parameters:
NUM_IRQ, 4, number of interrupt request lines (>=1)
IRQ_W, $clog2(NUM_IRQ) (min 1), width of int_id_o
TIMEOUT, 15, max bus cycles waited for an ack; 0 disables the timeout
TO_W, $clog2(TIMEOUT+1) (min 1), timeout counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
int_req  in  NUM_IRQ  level interrupt requests, bit 0 = highest priority
int_mask_i  in  NUM_IRQ  1 = source enabled
inst_ack_i  in  1  instruction bus ack
op_i  in  7  opcode from instruction bus
func_i  in  3  function field
data_ack_i  in  1  data/port bus ack
op2_c  out  1  ALU operand 2 select, 1 = immediate
ALUOp_o  out  4  ALU operation
ALUEN_o  out  1  ALU enable
ALUFR_o  out  1  flag register update
RegWrt_o  out  1  register file write
RegMux_c  out  2  writeback select: 00 ALU, 01 memory
PCEN_o  out  1  PC update enable
PCoper_o  out  4  PC operation
ret_o  out  1  return strobe
reti_o  out  1  return-from-interrupt strobe
int_o  out  1  interrupt entry strobe
stb_o  out  1  instruction bus strobe
cyc_o  out  1  instruction bus cycle
data_we_o  out  1  data write enable
port_we_o  out  1  port write enable
data_stb_o  out  1  data bus strobe
data_cyc_o  out  1  data bus cycle
int_ack_o  out  1  interrupt acknowledge
int_id_o  out  IRQ_W  index of the acknowledged source
fault_o  out  1  sticky fault flag

Behaviour:
- rst==0 at a clock edge: state=IDLE, timeout counter=0, in_service=0, fault cleared; all outputs 0.
- Outputs are a Moore decode of the state plus the latched op/func; every output not listed for a state is 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, INT, WAIT, FAULT.
- IDLE:
  - Entered only on reset.
  - First cycle with rst==1 moves to FETCH.
- FETCH:
  - cyc_o=stb_o=1.
  - On inst_ack_i: latch op_i/func_i, go to DECODE.
- DECODE (1 cycle), from the latched opcode:
  - op=1110000 ALU-reg: ALUOp={0,func}, op2_c=0.
  - op[6]=0 ALU-imm: ALUOp={0,op[5:3]}, op2_c=1.
  - op=1100000 shift: ALUOp={10,func[1:0]}.
  - op=1000000 memory: go to MEM.
  - op=1111000 jump; op=1111100 branch.
  - op=1111110 misc: func 000 nop, 001 ret, 010 reti, 011 wfi.
  - Any other opcode/func: go to FAULT.
- EXEC (1 cycle), then interrupt check:
  - ALU/shift: ALUEN_o=1, ALUFR_o=1, RegWrt_o=1, RegMux_c=00, PCEN_o=1, PCoper_o=0001.
  - jump: PCEN_o=1, PCoper_o=0010.
  - branch: ALUEN_o=1, ALUOp=1100, PCEN_o=1, PCoper_o={1,func}.
  - nop: PCEN_o=1, PCoper_o=0001.
  - ret: ret_o=1, PCEN_o=1, PCoper_o=0100.
  - reti: reti_o=1, PCEN_o=1, PCoper_o=0101, clears in_service.
  - wfi: PCEN_o=1, PCoper_o=0001, then WAIT.
- MEM:
  - data_cyc_o=data_stb_o=1.
  - func[0]=1 store; func[1] selects port: store drives port_we_o=1 instead of data_we_o=1.
  - On data_ack_i go to WB.
- WB (1 cycle), then interrupt check:
  - Always PCEN_o=1, PCoper_o=0001.
  - Load additionally drives RegWrt_o=1, RegMux_c=01.
- Interrupt check at the instruction boundary (leaving EXEC/WB):
  - pending = int_req & int_mask_i.
  - If pending!=0 and in_service==0, go to INT; otherwise go to FETCH.
- INT (1 cycle):
  - int_o=1, int_ack_o=1, PCEN_o=1, PCoper_o=1000.
  - int_id_o = lowest set index of pending, held until the next INT.
  - Sets in_service; then FETCH.
- WAIT:
  - All bus outputs 0.
  - Leave to INT when pending!=0 and in_service==0.
  - Leave to FETCH when pending!=0 and in_service==1.
- Timeout (TIMEOUT>0):
  - Counter clears on entering FETCH/MEM and increments each cycle there without ack.
  - An ack in any of the first TIMEOUT cycles is accepted.
  - Otherwise FAULT on the next edge.
- FAULT:
  - fault_o=1; all bus strobes and enables 0.
  - Held until reset.
- Latency with zero-wait acks:
  - ALU/jump/branch/misc: 3 cycles (FETCH, DECODE, EXEC).
  - Load/store: 4 cycles (FETCH, DECODE, MEM, WB).
- Simultaneous events:
  - Reset beats any ack.
  - int_req is ignored outside the boundary check and WAIT.
  - An ack arriving in the same cycle the timeout expires is accepted.

Test Plan:
- Hold rst=0 for 3 cycles, then release with inst_ack_i=1, op 1110000 func 001 -> all outputs 0 during reset; FETCH, DECODE, EXEC; EXEC shows ALUOp=0001, RegWrt_o=1, PCoper_o=0001.
- Load op 1000000 func 000, data_ack_i held low 3 cycles -> data_cyc_o/data_stb_o high 4 cycles, then WB with RegMux_c=01, RegWrt_o=1.
- int_req=0110, int_mask_i=0100 during an ALU instruction -> INT after EXEC with int_id_o=2, PCoper_o=1000; a second request is blocked until reti (op 1111110 func 010) clears in_service.
- wfi with no requests for 10 cycles, then int_req[0]=1 with mask bit 0 set -> stays in WAIT, then INT with int_id_o=0.
- TIMEOUT=4, inst_ack_i=0 -> stb_o high 4 cycles, then fault_o=1 sticky; rst=0 clears it.
- Opcode 0110000 via ALU-imm -> op2_c=1, ALUOp=0110; undefined op 1010101 -> FAULT.

Source files
------------

// File: rtl/control_unit_mc.sv
// Multi-cycle processor control unit: fetch/decode/execute/memory/writeback sequencing
// over Wishbone-style handshakes, with prioritised maskable interrupts, WFI and bus-timeout fault.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | post-reset, one cycle before the first fetch
// S_FETCH  | instruction bus cycle, waiting for inst_ack_i
// S_DECODE | classify latched opcode, present ALU operation
// S_EXEC   | drive datapath for ALU/jump/branch/misc, then boundary check
// S_MEM    | data/port bus cycle, waiting for data_ack_i
// S_WB     | writeback of load result / PC advance, then boundary check
// S_INT    | interrupt entry, vector PC and mark in-service
// S_WAIT   | wait-for-interrupt, buses idle
// S_FAULT  | illegal opcode or bus timeout, held until reset
module control_unit_mc #(
   parameter int NUM_IRQ = 4,
   parameter int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
   parameter int TIMEOUT = 15,
   parameter int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] int_req,
   input  logic [NUM_IRQ-1:0] int_mask_i,
   input  logic               inst_ack_i,
   input  logic [6:0]         op_i,
   input  logic [2:0]         func_i,
   input  logic               data_ack_i,
   output logic               op2_c,
   output logic [3:0]         ALUOp_o,
   output logic               ALUEN_o,
   output logic               ALUFR_o,
   output logic               RegWrt_o,
   output logic [1:0]         RegMux_c,
   output logic               PCEN_o,
   output logic [3:0]         PCoper_o,
   output logic               ret_o,
   output logic               reti_o,
   output logic               int_o,
   output logic               stb_o,
   output logic               cyc_o,
   output logic               data_we_o,
   output logic               port_we_o,
   output logic               data_stb_o,
   output logic               data_cyc_o,
   output logic               int_ack_o,
   output logic [IRQ_W-1:0]   int_id_o,
   output logic               fault_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_INT, S_WAIT, S_FAULT
   } state_t;

   typedef enum logic [3:0] {
      I_ALU, I_IMM, I_SHIFT, I_MEM, I_JUMP, I_BRANCH,
      I_NOP, I_RET, I_RETI, I_WFI, I_BAD
   } iclass_t;

   // Last counter value at which an ack is still accepted.
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

   state_t           state_q, state_d;
   logic [6:0]       op_q, op_d;
   logic [2:0]       func_q, func_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             in_service_q, in_service_d;
   logic [IRQ_W-1:0] int_id_q, int_id_d;

   iclass_t          iclass;
   logic [NUM_IRQ-1:0] pending;
   logic [IRQ_W-1:0] first_id;
   logic             int_take;
   logic             to_expired;
   logic [3:0]       alu_op_sel;
   logic             op2_sel;

   assign pending    = int_req & int_mask_i;
   assign int_take   = (|pending) && !in_service_q;
   assign to_expired = (TIMEOUT > 0) && (to_cnt_q == TO_LAST);
   assign int_id_o   = int_id_q;

   always_comb begin
      first_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) first_id = IRQ_W'(i);
      end
   end

   always_comb begin
      iclass = I_BAD;
      if (!op_q[6]) begin
         iclass = I_IMM;
      end else begin
         case (op_q)
            7'b1110000: iclass = I_ALU;
            7'b1100000: iclass = I_SHIFT;
            7'b1000000: iclass = I_MEM;
            7'b1111000: iclass = I_JUMP;
            7'b1111100: iclass = I_BRANCH;
            7'b1111110: begin
               case (func_q)
                  3'b000:  iclass = I_NOP;
                  3'b001:  iclass = I_RET;
                  3'b010:  iclass = I_RETI;
                  3'b011:  iclass = I_WFI;
                  default: iclass = I_BAD;
               endcase
            end
            default:    iclass = I_BAD;
         endcase
      end
   end

   always_comb begin
      alu_op_sel = 4'b0000;
      op2_sel    = 1'b0;
      case (iclass)
         I_ALU:   alu_op_sel = {1'b0, func_q};
         I_IMM: begin
            alu_op_sel = {1'b0, op_q[5:3]};
            op2_sel    = 1'b1;
         end
         I_SHIFT: alu_op_sel = {2'b10, func_q[1:0]};
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      func_d       = func_q;
      to_cnt_d     = '0;
      in_service_d = in_service_q;
      int_id_d     = int_id_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH: begin
            if (inst_ack_i) begin
               state_d = S_DECODE;
               op_d    = op_i;
               func_d  = func_i;
            end else if (to_expired) begin
               state_d = S_FAULT;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_DECODE: begin
            case (iclass)
               I_MEM:   state_d = S_MEM;
               I_BAD:   state_d = S_FAULT;
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            if (iclass == I_WFI) begin
               state_d = S_WAIT;
            end else begin
               // The boundary check sees in_service as it stood before this reti.
               if (iclass == I_RETI) in_service_d = 1'b0;
               state_d = int_take ? S_INT : S_FETCH;
            end
         end
         S_MEM: begin
            if (data_ack_i) begin
               state_d = S_WB;
            end else if (to_expired) begin
               state_d = S_FAULT;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_WB:     state_d = int_take ? S_INT : S_FETCH;
         S_INT: begin
            in_service_d = 1'b1;
            state_d      = S_FETCH;
         end
         S_WAIT: begin
            if (|pending) state_d = in_service_q ? S_FETCH : S_INT;
         end
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
      if (state_d == S_INT) int_id_d = first_id;
   end

   always_comb begin
      op2_c      = 1'b0;
      ALUOp_o    = 4'b0000;
      ALUEN_o    = 1'b0;
      ALUFR_o    = 1'b0;
      RegWrt_o   = 1'b0;
      RegMux_c   = 2'b00;
      PCEN_o     = 1'b0;
      PCoper_o   = 4'b0000;
      ret_o      = 1'b0;
      reti_o     = 1'b0;
      int_o      = 1'b0;
      stb_o      = 1'b0;
      cyc_o      = 1'b0;
      data_we_o  = 1'b0;
      port_we_o  = 1'b0;
      data_stb_o = 1'b0;
      data_cyc_o = 1'b0;
      int_ack_o  = 1'b0;
      fault_o    = 1'b0;
      case (state_q)
         S_FETCH: begin
            cyc_o = 1'b1;
            stb_o = 1'b1;
         end
         S_DECODE: begin
            ALUOp_o = alu_op_sel;
            op2_c   = op2_sel;
         end
         S_EXEC: begin
            case (iclass)
               I_ALU, I_IMM, I_SHIFT: begin
                  ALUOp_o  = alu_op_sel;
                  op2_c    = op2_sel;
                  ALUEN_o  = 1'b1;
                  ALUFR_o  = 1'b1;
                  RegWrt_o = 1'b1;
                  RegMux_c = 2'b00;
                  PCEN_o   = 1'b1;
                  PCoper_o = 4'b0001;
               end
               I_JUMP: begin
                  PCEN_o   = 1'b1;
                  PCoper_o = 4'b0010;
               end
               I_BRANCH: begin
                  ALUEN_o  = 1'b1;
                  ALUOp_o  = 4'b1100;
                  PCEN_o   = 1'b1;
                  PCoper_o = {1'b1, func_q};
               end
               I_NOP, I_WFI: begin
                  PCEN_o   = 1'b1;
                  PCoper_o = 4'b0001;
               end
               I_RET: begin
                  ret_o    = 1'b1;
                  PCEN_o   = 1'b1;
                  PCoper_o = 4'b0100;
               end
               I_RETI: begin
                  reti_o   = 1'b1;
                  PCEN_o   = 1'b1;
                  PCoper_o = 4'b0101;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            data_cyc_o = 1'b1;
            data_stb_o = 1'b1;
            if (func_q[0]) begin
               if (func_q[1]) port_we_o = 1'b1;
               else           data_we_o = 1'b1;
            end
         end
         S_WB: begin
            PCEN_o   = 1'b1;
            PCoper_o = 4'b0001;
            if (!func_q[0]) begin
               RegWrt_o = 1'b1;
               RegMux_c = 2'b01;
            end
         end
         S_INT: begin
            int_o     = 1'b1;
            int_ack_o = 1'b1;
            PCEN_o    = 1'b1;
            PCoper_o  = 4'b1000;
         end
         S_FAULT:  fault_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         func_q       <= '0;
         to_cnt_q     <= '0;
         in_service_q <= 1'b0;
         int_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         func_q       <= func_d;
         to_cnt_q     <= to_cnt_d;
         in_service_q <= in_service_d;
         int_id_q     <= int_id_d;
      end
   end

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: per-cycle stimulus and expected Moore outputs are
// queued together, then replayed and compared one cycle at a time.
module tb_control_unit_mc;

   logic       clk;
   logic       rst;
   logic [3:0] int_req;
   logic [3:0] int_mask_i;
   logic       inst_ack_i;
   logic [6:0] op_i;
   logic [2:0] func_i;
   logic       data_ack_i;
   logic       op2_c, ALUEN_o, ALUFR_o, RegWrt_o, PCEN_o, ret_o, reti_o, int_o;
   logic       stb_o, cyc_o, data_we_o, port_we_o, data_stb_o, data_cyc_o, int_ack_o, fault_o;
   logic [3:0] ALUOp_o, PCoper_o;
   logic [1:0] RegMux_c, int_id_o;

   typedef struct packed {
      logic       op2;
      logic [3:0] aluop;
      logic       aluen, alufr, regwrt;
      logic [1:0] regmux;
      logic       pcen;
      logic [3:0] pcoper;
      logic       ret, reti, intr, stb, cyc, dwe, pwe, dstb, dcyc, iack;
      logic [1:0] id;
      logic       fault;
   } outs_t;

   outs_t outs;

   control_unit_mc #(.NUM_IRQ(4), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .int_req(int_req), .int_mask_i(int_mask_i),
      .inst_ack_i(inst_ack_i), .op_i(op_i), .func_i(func_i), .data_ack_i(data_ack_i),
      .op2_c(op2_c), .ALUOp_o(ALUOp_o), .ALUEN_o(ALUEN_o), .ALUFR_o(ALUFR_o),
      .RegWrt_o(RegWrt_o), .RegMux_c(RegMux_c), .PCEN_o(PCEN_o), .PCoper_o(PCoper_o),
      .ret_o(ret_o), .reti_o(reti_o), .int_o(int_o), .stb_o(stb_o), .cyc_o(cyc_o),
      .data_we_o(data_we_o), .port_we_o(port_we_o), .data_stb_o(data_stb_o),
      .data_cyc_o(data_cyc_o), .int_ack_o(int_ack_o), .int_id_o(int_id_o), .fault_o(fault_o)
   );

   assign outs = '{op2: op2_c, aluop: ALUOp_o, aluen: ALUEN_o, alufr: ALUFR_o,
                   regwrt: RegWrt_o, regmux: RegMux_c, pcen: PCEN_o, pcoper: PCoper_o,
                   ret: ret_o, reti: reti_o, intr: int_o, stb: stb_o, cyc: cyc_o,
                   dwe: data_we_o, pwe: port_we_o, dstb: data_stb_o, dcyc: data_cyc_o,
                   iack: int_ack_o, id: int_id_o, fault: fault_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   string       q_tag[$];
   outs_t       q_exp[$];
   logic [15:0] q_in[$];

   logic [3:0] irq_cur;
   logic [6:0] op_cur;
   logic [2:0] func_cur;
   logic [1:0] cur_id;

   task automatic chk(input string tag, input outs_t got, input outs_t exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic outs_t b();
      outs_t o;
      o    = '0;
      o.id = cur_id;
      return o;
   endfunction

   task automatic push(input string tag, input outs_t e, input logic ia, input logic da);
      q_tag.push_back(tag);
      q_exp.push_back(e);
      q_in.push_back({ia, da, irq_cur, op_cur, func_cur});
   endtask

   task automatic run_all();
      while (q_exp.size() > 0) begin
         string       t;
         outs_t       e;
         logic [15:0] in;
         t  = q_tag.pop_front();
         e  = q_exp.pop_front();
         in = q_in.pop_front();
         chk(t, outs, e);
         {inst_ack_i, data_ack_i, int_req, op_i, func_i} = in;
         @(negedge clk);
      end
   endtask

   task automatic p_fetch(input string t, input logic ia);
      outs_t e;
      e = b(); e.stb = 1'b1; e.cyc = 1'b1;
      push({t, "_fetch"}, e, ia, 1'b0);
   endtask

   task automatic ins_alu(input string t, input logic [6:0] op, input logic [2:0] fn,
                          input logic [3:0] aop, input logic op2);
      outs_t e;
      op_cur = op; func_cur = fn;
      p_fetch(t, 1'b1);
      e = b(); e.aluop = aop; e.op2 = op2;
      push({t, "_dec"}, e, 1'b0, 1'b0);
      e.aluen = 1'b1; e.alufr = 1'b1; e.regwrt = 1'b1; e.pcen = 1'b1; e.pcoper = 4'b0001;
      push({t, "_exec"}, e, 1'b0, 1'b0);
   endtask

   task automatic ins_ex(input string t, input logic [6:0] op, input logic [2:0] fn,
                         input outs_t ex);
      op_cur = op; func_cur = fn;
      p_fetch(t, 1'b1);
      push({t, "_dec"}, b(), 1'b0, 1'b0);
      push({t, "_exec"}, ex, 1'b0, 1'b0);
   endtask

   task automatic ins_mem(input string t, input logic [2:0] fn, input int waits);
      outs_t e;
      op_cur = 7'b1000000; func_cur = fn;
      p_fetch(t, 1'b1);
      push({t, "_dec"}, b(), 1'b0, 1'b0);
      e = b(); e.dcyc = 1'b1; e.dstb = 1'b1;
      e.dwe = fn[0] & ~fn[1]; e.pwe = fn[0] & fn[1];
      for (int i = 0; i <= waits; i++) push({t, "_mem"}, e, 1'b0, (i == waits));
      e = b(); e.pcen = 1'b1; e.pcoper = 4'b0001;
      if (!fn[0]) begin e.regwrt = 1'b1; e.regmux = 2'b01; end
      push({t, "_wb"}, e, 1'b0, 1'b0);
   endtask

   task automatic p_int(input string t, input logic [1:0] id);
      outs_t e;
      cur_id = id;
      e = b(); e.intr = 1'b1; e.iack = 1'b1; e.pcen = 1'b1; e.pcoper = 4'b1000;
      push(t, e, 1'b0, 1'b0);
   endtask

   task automatic p_fault(input string t, input int n);
      outs_t e;
      e = b(); e.fault = 1'b1;
      for (int i = 0; i < n; i++) push(t, e, 1'b1, 1'b1);
   endtask

   // Reset with acks and requests asserted; reset must win over all of them.
   task automatic do_reset();
      rst = 1'b0; inst_ack_i = 1'b1; data_ack_i = 1'b1; int_req = 4'hF;
      repeat (3) @(negedge clk);
      cur_id = 2'd0; irq_cur = 4'h0;
      push("reset", b(), 1'b1, 1'b0);
      rst = 1'b1;
      run_all();
   endtask

   outs_t ex;

   initial begin
      rst = 1'b0; int_req = '0; int_mask_i = 4'b1100; inst_ack_i = 1'b0;
      data_ack_i = 1'b0; op_i = '0; func_i = '0;
      irq_cur = '0; op_cur = 7'b1110000; func_cur = 3'b001; cur_id = '0;
      do_reset();

      ins_alu("alu_reg", 7'b1110000, 3'b001, 4'b0001, 1'b0);
      ins_mem("load", 3'b000, 3);
      ins_mem("store", 3'b001, 0);
      ins_mem("port_st", 3'b011, 0);
      irq_cur = 4'b0110;
      ins_alu("alu_imm", 7'b0110000, 3'b000, 4'b0110, 1'b1);
      p_int("int_id2", 2'd2);
      ins_alu("shift", 7'b1100000, 3'b011, 4'b1011, 1'b0);
      ex = b(); ex.pcen = 1'b1; ex.pcoper = 4'b0010;
      ins_ex("jump", 7'b1111000, 3'b000, ex);
      irq_cur = 4'b0000;
      ex = b(); ex.reti = 1'b1; ex.pcen = 1'b1; ex.pcoper = 4'b0101;
      ins_ex("reti1", 7'b1111110, 3'b010, ex);
      irq_cur = 4'b1000;
      ex = b(); ex.pcen = 1'b1; ex.pcoper = 4'b0001;
      ins_ex("nop", 7'b1111110, 3'b000, ex);
      p_int("int_id3", 2'd3);
      ex = b(); ex.aluen = 1'b1; ex.aluop = 4'b1100; ex.pcen = 1'b1; ex.pcoper = 4'b1101;
      ins_ex("branch", 7'b1111100, 3'b101, ex);
      irq_cur = 4'b0000;
      ex = b(); ex.reti = 1'b1; ex.pcen = 1'b1; ex.pcoper = 4'b0101;
      ins_ex("reti2", 7'b1111110, 3'b010, ex);
      ex = b(); ex.ret = 1'b1; ex.pcen = 1'b1; ex.pcoper = 4'b0100;
      ins_ex("ret", 7'b1111110, 3'b001, ex);
      run_all();

      int_mask_i = 4'b0001;
      ex = b(); ex.pcen = 1'b1; ex.pcoper = 4'b0001;
      ins_ex("wfi1", 7'b1111110, 3'b011, ex);
      for (int i = 0; i < 10; i++) push("wait_idle", b(), 1'b0, 1'b0);
      irq_cur = 4'b0001;
      push("wait_wake", b(), 1'b0, 1'b0);
      p_int("int_id0", 2'd0);
      irq_cur = 4'b0000;
      ex = b(); ex.pcen = 1'b1; ex.pcoper = 4'b0001;
      ins_ex("wfi2", 7'b1111110, 3'b011, ex);
      push("wait2", b(), 1'b0, 1'b0);
      irq_cur = 4'b0001;
      push("wait2_wake", b(), 1'b0, 1'b0);
      irq_cur = 4'b0000;
      ex = b(); ex.reti = 1'b1; ex.pcen = 1'b1; ex.pcoper = 4'b0101;
      ins_ex("reti3", 7'b1111110, 3'b010, ex);
      op_cur = 7'b1010101; func_cur = 3'b000;
      p_fetch("undef", 1'b1);
      push("undef_dec", b(), 1'b0, 1'b0);
      p_fault("undef_fault", 3);
      run_all();

      do_reset();
      op_cur = 7'b1110000; func_cur = 3'b000;
      for (int i = 0; i < 4; i++) p_fetch("tmo", 1'b0);
      p_fault("tmo_fault", 3);
      run_all();

      do_reset();
      op_cur = 7'b1111110; func_cur = 3'b100;
      p_fetch("misc_bad", 1'b1);
      push("misc_bad_dec", b(), 1'b0, 1'b0);
      p_fault("misc_bad_fault", 2);
      run_all();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
